// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshake and SRAM strobe bundle for sram_arbiter.
interface sram_arbiter_if #(parameter int AW = 20);
    logic          req_cpu;
    logic          req_ld;
    logic          we_cpu;
    logic          we_ld;
    logic [AW-1:0] addr_cpu;
    logic [AW-1:0] addr_ld;
    logic [15:0]   wdata_cpu;
    logic [15:0]   wdata_ld;
    logic          ack_cpu;
    logic          ack_ld;
    logic [15:0]   rdata;
    logic          grant_id;
    logic          busy;
    logic          Mem_CE;
    logic          Mem_UB;
    logic          Mem_LB;
    logic          Mem_OE;
    logic          Mem_WE;
    logic [AW-1:0] ADDR;
    logic [15:0]   Data_write;
    logic          data_oe;
    logic [15:0]   Data_read;

    modport slave (
        input  req_cpu, req_ld, we_cpu, we_ld, addr_cpu, addr_ld, wdata_cpu, wdata_ld, Data_read,
        output ack_cpu, ack_ld, rdata, grant_id, busy, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
               ADDR, Data_write, data_oe
    );

    modport master (
        output req_cpu, req_ld, we_cpu, we_ld, addr_cpu, addr_ld, wdata_cpu, wdata_ld, Data_read,
        input  ack_cpu, ack_ld, rdata, grant_id, busy, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
               ADDR, Data_write, data_oe
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one async 16-bit SRAM between cpu and loader ports.
// Fixed-latency read (3 cycles) and write (4 cycles) sequences with registered strobes.
module sram_arbiter #(parameter int AW = 20) (
    input logic          Clk,
    input logic          Reset,
    sram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3, DONE} state_t;

    state_t        state;
    logic          last_g;
    logic          win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [15:0]   win_wdata;

    always_comb begin
        win       = (bus.req_cpu && bus.req_ld) ? ~last_g : bus.req_ld;
        win_we    = win ? bus.we_ld : bus.we_cpu;
        win_addr  = win ? bus.addr_ld : bus.addr_cpu;
        win_wdata = win ? bus.wdata_ld : bus.wdata_cpu;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state          <= IDLE;
            last_g         <= 1'b1;
            bus.grant_id   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.ack_cpu    <= 1'b0;
            bus.ack_ld     <= 1'b0;
            bus.rdata      <= '0;
            bus.ADDR       <= '0;
            bus.Data_write <= '0;
            bus.data_oe    <= 1'b0;
            bus.Mem_CE     <= 1'b1;
            bus.Mem_UB     <= 1'b1;
            bus.Mem_LB     <= 1'b1;
            bus.Mem_OE     <= 1'b1;
            bus.Mem_WE     <= 1'b1;
        end else begin
            bus.ack_cpu <= 1'b0;
            bus.ack_ld  <= 1'b0;
            case (state)
                IDLE: if (bus.req_cpu || bus.req_ld) begin
                    state          <= win_we ? WR1 : RD1;
                    last_g         <= win;
                    bus.grant_id   <= win;
                    bus.busy       <= 1'b1;
                    bus.ADDR       <= win_addr;
                    bus.Data_write <= win_wdata;
                    bus.data_oe    <= win_we;
                    bus.Mem_CE     <= 1'b0;
                    bus.Mem_UB     <= 1'b0;
                    bus.Mem_LB     <= 1'b0;
                    bus.Mem_OE     <= win_we;
                    bus.Mem_WE     <= 1'b1;
                end
                RD1: state <= RD2;
                WR1: begin
                    state      <= WR2;
                    bus.Mem_WE <= 1'b0;
                end
                WR2: begin
                    state      <= WR3;
                    bus.Mem_WE <= 1'b1;
                end
                RD2, WR3: begin
                    // rdata only captures on the read path so writes leave it intact
                    if (state == RD2)
                        bus.rdata <= bus.Data_read;
                    state       <= DONE;
                    bus.ack_cpu <= ~bus.grant_id;
                    bus.ack_ld  <= bus.grant_id;
                    bus.data_oe <= 1'b0;
                    bus.Mem_CE  <= 1'b1;
                    bus.Mem_UB  <= 1'b1;
                    bus.Mem_LB  <= 1'b1;
                    bus.Mem_OE  <= 1'b1;
                    bus.Mem_WE  <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    bus.busy    <= 1'b0;
                    bus.data_oe <= 1'b0;
                    bus.Mem_CE  <= 1'b1;
                    bus.Mem_UB  <= 1'b1;
                    bus.Mem_LB  <= 1'b1;
                    bus.Mem_OE  <= 1'b1;
                    bus.Mem_WE  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenario checks for sram_arbiter against a one-entry SRAM model.
module tb_sram_arbiter;
    logic Clk;
    logic Reset;
    int   pass_cnt;
    int   chk_cnt;

    sram_arbiter_if #(.AW(20)) bus ();
    sram_arbiter #(.AW(20)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // memory model: remembers the last written word, fixed pattern elsewhere
    bit          have_w;
    logic [19:0] w_addr;
    logic [15:0] w_data;
    always @(posedge Clk)
        if (!bus.Mem_CE && !bus.Mem_WE) begin
            have_w <= 1'b1;
            w_addr <= bus.ADDR;
            w_data <= bus.Data_write;
        end
    assign bus.Data_read = (have_w && bus.ADDR == w_addr) ? w_data :
                           (bus.ADDR == 20'h00012) ? 16'hBEEF : {8'h5A, bus.ADDR[7:0]};

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_access(input logic who, input logic we, input logic [19:0] addr,
                             input logic [15:0] wdata, output int ack_at, output int oe_low,
                             output int we_low, output int we_low_at, output int doe_high,
                             output int bad, output logic [15:0] rd_mid);
        ack_at = 0; oe_low = 0; we_low = 0; we_low_at = 0; doe_high = 0; bad = 0; rd_mid = '0;
        if (who) begin
            bus.req_ld = 1'b1; bus.we_ld = we; bus.addr_ld = addr; bus.wdata_ld = wdata;
        end else begin
            bus.req_cpu = 1'b1; bus.we_cpu = we; bus.addr_cpu = addr; bus.wdata_cpu = wdata;
        end
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (i == 2) rd_mid = bus.rdata;
            if (!bus.Mem_OE) oe_low++;
            if (!bus.Mem_WE) begin we_low++; we_low_at = i; end
            if (bus.data_oe) doe_high++;
            if ((bus.ack_cpu && bus.ack_ld) || (bus.data_oe && !bus.Mem_OE)) bad++;
            if ((who ? bus.ack_cpu : bus.ack_ld)) bad++;
            if ((who ? bus.ack_ld : bus.ack_cpu) && ack_at == 0) begin
                ack_at = i;
                bus.req_cpu = 1'b0;
                bus.req_ld  = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        tick; tick;
        chk_cnt++; if ({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE} !== 5'h1f) $display("FAIL reset_strobes got %b exp 11111", {bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE}); else pass_cnt++;
        chk_cnt++; if (bus.data_oe !== 1'b0) $display("FAIL reset_data_oe got %b exp 0", bus.data_oe); else pass_cnt++;
        chk_cnt++; if ({bus.ack_cpu, bus.ack_ld} !== 2'b00) $display("FAIL reset_acks got %b exp 00", {bus.ack_cpu, bus.ack_ld}); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.ADDR !== 20'h0) $display("FAIL reset_addr got %h exp 00000", bus.ADDR); else pass_cnt++;
        chk_cnt++; if (bus.Data_write !== 16'h0) $display("FAIL reset_data_write got %h exp 0000", bus.Data_write); else pass_cnt++;
        chk_cnt++; if (bus.rdata !== 16'h0) $display("FAIL reset_rdata got %h exp 0000", bus.rdata); else pass_cnt++;
        chk_cnt++; if (bus.grant_id !== 1'b0) $display("FAIL reset_grant got %b exp 0", bus.grant_id); else pass_cnt++;
        Reset = 1'b1;
    endtask

    task automatic test_cpu_read;
        int ack_at, oe_low, we_low, we_low_at, doe_high, bad;
        logic [15:0] rd_mid;
        do_access(1'b0, 1'b0, 20'h00012, 16'h0, ack_at, oe_low, we_low, we_low_at, doe_high, bad, rd_mid);
        chk_cnt++; if (ack_at !== 3) $display("FAIL rd_ack_latency got %0d exp 3", ack_at); else pass_cnt++;
        chk_cnt++; if (oe_low !== 2) $display("FAIL rd_oe_low_cycles got %0d exp 2", oe_low); else pass_cnt++;
        chk_cnt++; if (we_low !== 0 || doe_high !== 0) $display("FAIL rd_no_drive got we_low=%0d doe=%0d exp 0 0", we_low, doe_high); else pass_cnt++;
        chk_cnt++; if (bus.rdata !== 16'hBEEF) $display("FAIL rd_rdata got %h exp beef", bus.rdata); else pass_cnt++;
        chk_cnt++; if (bus.grant_id !== 1'b0) $display("FAIL rd_grant got %b exp 0", bus.grant_id); else pass_cnt++;
        chk_cnt++; if (bad !== 0) $display("FAIL rd_protocol got %0d violations exp 0", bad); else pass_cnt++;
    endtask

    task automatic test_ld_write;
        int ack_at, oe_low, we_low, we_low_at, doe_high, bad;
        logic [15:0] rd_mid;
        do_access(1'b1, 1'b1, 20'h00040, 16'h1234, ack_at, oe_low, we_low, we_low_at, doe_high, bad, rd_mid);
        chk_cnt++; if (ack_at !== 4) $display("FAIL wr_ack_latency got %0d exp 4", ack_at); else pass_cnt++;
        chk_cnt++; if (doe_high !== 3) $display("FAIL wr_data_oe_cycles got %0d exp 3", doe_high); else pass_cnt++;
        chk_cnt++; if (we_low !== 1 || we_low_at !== 2) $display("FAIL wr_we_pulse got n=%0d at=%0d exp n=1 at=2", we_low, we_low_at); else pass_cnt++;
        chk_cnt++; if (oe_low !== 0) $display("FAIL wr_oe got %0d low cycles exp 0", oe_low); else pass_cnt++;
        chk_cnt++; if (bus.ADDR !== 20'h00040 || bus.Data_write !== 16'h1234) $display("FAIL wr_hold got %h/%h exp 00040/1234", bus.ADDR, bus.Data_write); else pass_cnt++;
        chk_cnt++; if (bus.grant_id !== 1'b1) $display("FAIL wr_grant got %b exp 1", bus.grant_id); else pass_cnt++;
        chk_cnt++; if (bus.rdata !== 16'hBEEF) $display("FAIL wr_rdata_kept got %h exp beef", bus.rdata); else pass_cnt++;
        chk_cnt++; if (bad !== 0) $display("FAIL wr_protocol got %0d violations exp 0", bad); else pass_cnt++;
    endtask

    task automatic test_round_robin;
        logic [3:0] seq;
        int n, first_ack, both, gap_bad;
        logic gap;
        n = 0; first_ack = 0; both = 0; gap_bad = 0; gap = 1'b0; seq = '0;
        Reset = 1'b0;
        tick; tick;
        bus.req_cpu = 1'b1; bus.we_cpu = 1'b0; bus.addr_cpu = 20'h00012;
        bus.req_ld  = 1'b1; bus.we_ld  = 1'b0; bus.addr_ld  = 20'h00013;
        Reset = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick;
            if (bus.ack_cpu && bus.ack_ld) both++;
            if (bus.ack_cpu || bus.ack_ld) begin
                if (n == 0) first_ack = i;
                if (n > 0 && !gap) gap_bad++;
                if (n < 4) seq[n] = bus.ack_ld;
                gap = 1'b0;
                n++;
            end
            if (!bus.busy) gap = 1'b1;
        end
        bus.req_cpu = 1'b0; bus.req_ld = 1'b0;
        tick; tick;
        chk_cnt++; if (first_ack !== 3) $display("FAIL rr_first_ack got %0d exp 3", first_ack); else pass_cnt++;
        chk_cnt++; if (n !== 6) $display("FAIL rr_ack_count got %0d exp 6", n); else pass_cnt++;
        chk_cnt++; if (seq !== 4'b1010) $display("FAIL rr_order got %b exp 1010 (ld,cpu,ld,cpu msb first)", seq); else pass_cnt++;
        chk_cnt++; if (both !== 0) $display("FAIL rr_both_acks got %0d exp 0", both); else pass_cnt++;
        chk_cnt++; if (gap_bad !== 0) $display("FAIL rr_idle_gap got %0d missing gaps exp 0", gap_bad); else pass_cnt++;
    endtask

    task automatic test_reset_abort;
        int ack_at;
        ack_at = 0;
        bus.req_ld = 1'b1; bus.we_ld = 1'b1; bus.addr_ld = 20'h00077; bus.wdata_ld = 16'hDEAD;
        tick;
        chk_cnt++; if (bus.data_oe !== 1'b1) $display("FAIL ab_wr1_data_oe got %b exp 1", bus.data_oe); else pass_cnt++;
        tick;
        chk_cnt++; if (bus.Mem_WE !== 1'b0) $display("FAIL ab_wr2_we got %b exp 0", bus.Mem_WE); else pass_cnt++;
        Reset = 1'b0;
        tick;
        chk_cnt++; if ({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE} !== 5'h1f) $display("FAIL ab_strobes got %b exp 11111", {bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE}); else pass_cnt++;
        chk_cnt++; if (bus.data_oe !== 1'b0 || bus.busy !== 1'b0) $display("FAIL ab_idle got oe=%b busy=%b exp 0 0", bus.data_oe, bus.busy); else pass_cnt++;
        chk_cnt++; if ({bus.ack_cpu, bus.ack_ld} !== 2'b00) $display("FAIL ab_no_ack got %b exp 00", {bus.ack_cpu, bus.ack_ld}); else pass_cnt++;
        Reset = 1'b1;
        tick;
        chk_cnt++; if (bus.busy !== 1'b1 || bus.grant_id !== 1'b1 || bus.ADDR !== 20'h00077) $display("FAIL ab_reaccept got busy=%b grant=%b addr=%h exp 1 1 00077", bus.busy, bus.grant_id, bus.ADDR); else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            tick;
            if (bus.ack_ld && ack_at == 0) begin ack_at = i; bus.req_ld = 1'b0; end
        end
        chk_cnt++; if (ack_at !== 3) $display("FAIL ab_final_ack got %0d exp 3", ack_at); else pass_cnt++;
    endtask

    task automatic test_addr_hold;
        bus.req_cpu = 1'b1; bus.we_cpu = 1'b0; bus.addr_cpu = 20'h00001;
        tick;
        chk_cnt++; if (bus.ADDR !== 20'h00001) $display("FAIL hold_rd1 got %h exp 00001", bus.ADDR); else pass_cnt++;
        bus.addr_cpu = 20'h00002;
        tick;
        chk_cnt++; if (bus.ADDR !== 20'h00001) $display("FAIL hold_rd2 got %h exp 00001", bus.ADDR); else pass_cnt++;
        tick;
        chk_cnt++; if (bus.ack_cpu !== 1'b1 || bus.rdata !== 16'h5A01) $display("FAIL hold_done got ack=%b rdata=%h exp 1 5a01", bus.ack_cpu, bus.rdata); else pass_cnt++;
        bus.req_cpu = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int ack_at, oe_low, we_low, we_low_at, doe_high, bad;
        logic [15:0] rd_mid;
        do_access(1'b0, 1'b1, 20'h00005, 16'hA5C3, ack_at, oe_low, we_low, we_low_at, doe_high, bad, rd_mid);
        chk_cnt++; if (rd_mid !== 16'h5A01 || bus.rdata !== 16'h5A01) $display("FAIL b2b_rdata_during_write got %h/%h exp 5a01", rd_mid, bus.rdata); else pass_cnt++;
        chk_cnt++; if (ack_at !== 4) $display("FAIL b2b_wr_latency got %0d exp 4", ack_at); else pass_cnt++;
        do_access(1'b0, 1'b0, 20'h00005, 16'h0, ack_at, oe_low, we_low, we_low_at, doe_high, bad, rd_mid);
        chk_cnt++; if (bus.rdata !== 16'hA5C3) $display("FAIL b2b_readback got %h exp a5c3", bus.rdata); else pass_cnt++;
        chk_cnt++; if (ack_at !== 3 || bad !== 0) $display("FAIL b2b_rd got ack_at=%0d bad=%0d exp 3 0", ack_at, bad); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; chk_cnt = 0;
        Reset = 1'b0;
        bus.req_cpu = 1'b0; bus.we_cpu = 1'b0; bus.addr_cpu = '0; bus.wdata_cpu = '0;
        bus.req_ld  = 1'b0; bus.we_ld  = 1'b0; bus.addr_ld  = '0; bus.wdata_ld  = '0;
        test_reset;
        test_cpu_read;
        test_ld_write;
        test_round_robin;
        test_reset_abort;
        test_addr_hold;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
